// File: rtl/rfid_gen2_pkg.sv
// Shared Gen2 tag definitions: state encodings, command framing, Query field
// offsets, CRC5 constants and the slot/RN16 LFSR step.
package rfid_gen2_pkg;

    typedef enum logic [1:0] {
        StReady        = 2'd0,
        StArbitrate    = 2'd1,
        StReply        = 2'd2,
        StAcknowledged = 2'd3
    } tag_state_e;

    typedef enum logic [1:0] {
        TxIdle = 2'd0,
        TxWait = 2'd1,
        TxSend = 2'd2
    } tx_phase_e;

    // Receive shift register width and command lengths in bits
    localparam int unsigned RxW      = 22;
    localparam logic [4:0]  QryLen   = 5'd22;
    localparam logic [4:0]  RepLen   = 5'd4;
    localparam logic [4:0]  AckLen   = 5'd18;
    localparam logic [4:0]  NakLen   = 5'd8;
    localparam logic [4:0]  RxCntOvf = 5'd23;

    // Command prefixes, first bit on air is the MSB
    localparam logic [3:0] QryPrefix = 4'b1000;
    localparam logic [1:0] RepPrefix = 2'b00;
    localparam logic [1:0] AckPrefix = 2'b01;
    localparam logic [7:0] NakCode   = 8'b1100_0000;

    // Query field offsets inside the 22-bit frame
    localparam int unsigned QrySessLsb = 10;
    localparam int unsigned QryQLsb    = 5;

    // CRC5 x^5+x^3+1
    localparam logic [4:0] Crc5Preset = 5'b01001;
    localparam logic [4:0] Crc5Poly   = 5'b01001;

    // Fibonacci taps 16,14,13,11 seen from the shift-right end (bits 0,2,3,5)
    localparam logic [15:0] LfsrTapMask = 16'b0000_0000_0010_1101;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LfsrTapMask), s[15:1]};
    endfunction

endpackage

// File: rtl/rfid_crc5_chk.sv
// Serial CRC5 checker over a received reader frame. ok_o reflects the residue
// including any bit shifted on the current cycle, so it can be used on in_eof.
module rfid_crc5_chk
    import rfid_gen2_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic shift_i,
    input  logic dat_i,
    output logic ok_o
);

    logic [4:0] crc_q, crc_d;
    logic       fb;

    // Next residue: clear first, then shift the incoming bit
    always_comb begin
        crc_d = crc_q;
        fb    = 1'b0;
        if (clr_i) begin
            crc_d = Crc5Preset;
        end
        if (shift_i) begin
            fb    = crc_d[4] ^ dat_i;
            crc_d = {crc_d[3:0], 1'b0} ^ (fb ? Crc5Poly : 5'b0);
        end
    end

    assign ok_o = (crc_d == 5'd0);

    // Residue register
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= Crc5Preset;
        end else begin
            crc_q <= crc_d;
        end
    end

endmodule

// File: rtl/rfid_tag_fsm.sv
// Gen2 tag inventory responder: decodes Query/QueryRep/ACK/NAK from the PIE
// decoder, runs the slot-count state machine and serialises RN16 or
// PC+EPC+CRC16 replies over a valid/ready bit handshake.
// Optional: define RFID_TAG_CRC5_EN to reject Query frames with a bad CRC5.
module rfid_tag_fsm
    import rfid_gen2_pkg::*;
#(
    parameter int unsigned EPC_W     = 96,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int unsigned T1_CYCLES = 64,
    parameter int unsigned T2_MAX    = 2000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_dat,
    input  logic             in_vld,
    input  logic             in_sof,
    input  logic             in_eof,
    input  logic [15:0]      epc_pc,
    input  logic [EPC_W-1:0] epc_val,
    input  logic [15:0]      epc_crc,
    output logic             out_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic             out_last,
    output logic [1:0]       state_o
);

    localparam int unsigned TxW    = 32 + EPC_W;
    localparam int unsigned TxCntW = $clog2(TxW + 1);
    localparam int unsigned T1W    = $clog2(T1_CYCLES + 1);
    localparam int unsigned T2W    = $clog2(T2_MAX + 1);

    tag_state_e        state_q, state_d;
    logic [14:0]       slot_q, slot_d;
    logic [1:0]        session_q, session_d;
    logic [15:0]       rn_q, rn_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [RxW-1:0]    rx_sr_q, rx_sr_d;
    logic [4:0]        rx_cnt_q, rx_cnt_d;
    tx_phase_e         tx_phase_q, tx_phase_d;
    logic [TxW-1:0]    tx_sr_q, tx_sr_d;
    logic [TxCntW-1:0] tx_left_q, tx_left_d;
    logic [T1W-1:0]    t1_cnt_q, t1_cnt_d;
    logic              t2_run_q, t2_run_d;
    logic [T2W-1:0]    t2_cnt_q, t2_cnt_d;

    logic        tx_busy, rx_acc, crc_ok, frame_end;
    logic        is_qry, is_rep, is_ack, is_nak, cmd_valid;
    logic        send_rn, send_epc, t2_expire, tx_last_hs;
    logic [14:0] q_mask;

    assign tx_busy = (tx_phase_q != TxIdle);
    assign rx_acc  = in_vld & ~tx_busy;

    // Receive shifter; while a reply is in flight the count is parked at
    // overflow so the whole frame is dropped until the next in_sof
    always_comb begin
        rx_sr_d  = rx_sr_q;
        rx_cnt_d = rx_cnt_q;
        if (tx_busy) begin
            rx_cnt_d = RxCntOvf;
        end else begin
            if (in_sof) begin
                rx_cnt_d = 5'd0;
            end
            if (in_vld) begin
                rx_sr_d = {rx_sr_q[RxW-2:0], in_dat};
                if (rx_cnt_d != RxCntOvf) begin
                    rx_cnt_d = rx_cnt_d + 5'd1;
                end
            end
        end
    end

`ifdef RFID_TAG_CRC5_EN
    rfid_crc5_chk u_crc5_chk (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (in_sof & ~tx_busy),
        .shift_i (rx_acc),
        .dat_i   (in_dat),
        .ok_o    (crc_ok)
    );
`else
    assign crc_ok = 1'b1;
`endif

    // Command decode on frame end, using the shifter state including this cycle's bit
    assign frame_end = in_eof & ~tx_busy;
    assign is_qry = frame_end && (rx_cnt_d == QryLen) && (rx_sr_d[21:18] == QryPrefix) && crc_ok;
    assign is_rep = frame_end && (rx_cnt_d == RepLen) && (rx_sr_d[3:2] == RepPrefix);
    assign is_ack = frame_end && (rx_cnt_d == AckLen) && (rx_sr_d[17:16] == AckPrefix);
    assign is_nak = frame_end && (rx_cnt_d == NakLen) && (rx_sr_d[7:0] == NakCode);
    assign cmd_valid = is_qry | is_rep | is_ack | is_nak;

    assign lfsr_d    = rx_acc ? lfsr_next(lfsr_q) : lfsr_q;
    assign q_mask    = ~(15'h7fff << rx_sr_d[QryQLsb +: 4]);
    assign t2_expire = t2_run_q && (t2_cnt_q == T2W'(T2_MAX - 1));

    // Slot-count state machine; decisions use the LFSR value after this cycle's bit
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        session_d = session_q;
        rn_d      = rn_q;
        send_rn   = 1'b0;
        send_epc  = 1'b0;
        if (is_qry) begin
            session_d = rx_sr_d[QrySessLsb +: 2];
            slot_d    = lfsr_d[14:0] & q_mask;
            if (slot_d == 15'd0) begin
                state_d = StReply;
                rn_d    = lfsr_d;
                send_rn = 1'b1;
            end else begin
                state_d = StArbitrate;
            end
        end else if (is_rep) begin
            if (rx_sr_d[1:0] == session_q) begin
                case (state_q)
                    StArbitrate: begin
                        slot_d = slot_q - 15'd1;
                        if (slot_d == 15'd0) begin
                            state_d = StReply;
                            rn_d    = lfsr_d;
                            send_rn = 1'b1;
                        end
                    end
                    StReply:        state_d = StArbitrate;
                    StAcknowledged: state_d = StReady;
                    default:        ;
                endcase
            end
        end else if (is_ack) begin
            if (state_q == StReply || state_q == StAcknowledged) begin
                if (rx_sr_d[15:0] == rn_q) begin
                    state_d  = StAcknowledged;
                    send_epc = 1'b1;
                end else begin
                    state_d = StArbitrate;
                end
            end
        end else if (is_nak) begin
            if (state_q != StReady) begin
                state_d = StArbitrate;
            end
        end else if (t2_expire) begin
            state_d = StArbitrate;
        end
    end

    assign tx_last_hs = out_vld && out_rdy && (tx_left_q == TxCntW'(1));

    // T2 reply-to-command timer, armed by the final reply handshake
    always_comb begin
        t2_run_d = t2_run_q;
        t2_cnt_d = t2_cnt_q;
        if (cmd_valid) begin
            t2_run_d = 1'b0;
        end else if (tx_last_hs && (state_q == StReply || state_q == StAcknowledged)) begin
            t2_run_d = 1'b1;
            t2_cnt_d = '0;
        end else if (t2_run_q) begin
            if (t2_expire) begin
                t2_run_d = 1'b0;
            end else begin
                t2_cnt_d = t2_cnt_q + T2W'(1);
            end
        end
    end

    // Reply sequencer: T1 wait, then MSB-first shift-out on each handshake
    always_comb begin
        tx_phase_d = tx_phase_q;
        tx_sr_d    = tx_sr_q;
        tx_left_d  = tx_left_q;
        t1_cnt_d   = t1_cnt_q;
        case (tx_phase_q)
            TxIdle: begin
                if (send_rn) begin
                    tx_sr_d    = {rn_d, {(TxW - 16){1'b0}}};
                    tx_left_d  = TxCntW'(16);
                    t1_cnt_d   = '0;
                    tx_phase_d = TxWait;
                end else if (send_epc) begin
                    tx_sr_d    = {epc_pc, epc_val, epc_crc};
                    tx_left_d  = TxCntW'(TxW);
                    t1_cnt_d   = '0;
                    tx_phase_d = TxWait;
                end
            end
            TxWait: begin
                if (t1_cnt_q == T1W'(T1_CYCLES - 1)) begin
                    tx_phase_d = TxSend;
                end else begin
                    t1_cnt_d = t1_cnt_q + T1W'(1);
                end
            end
            TxSend: begin
                if (out_rdy) begin
                    tx_sr_d   = {tx_sr_q[TxW-2:0], 1'b0};
                    tx_left_d = tx_left_q - TxCntW'(1);
                    if (tx_left_q == TxCntW'(1)) begin
                        tx_phase_d = TxIdle;
                    end
                end
            end
            default: tx_phase_d = TxIdle;
        endcase
    end

    assign out_vld  = (tx_phase_q == TxSend);
    assign out_dat  = out_vld & tx_sr_q[TxW-1];
    assign out_last = out_vld && (tx_left_q == TxCntW'(1));
    assign state_o  = state_q;

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StReady;
            slot_q     <= '0;
            session_q  <= '0;
            rn_q       <= '0;
            lfsr_q     <= LFSR_SEED;
            rx_sr_q    <= '0;
            rx_cnt_q   <= '0;
            tx_phase_q <= TxIdle;
            tx_sr_q    <= '0;
            tx_left_q  <= '0;
            t1_cnt_q   <= '0;
            t2_run_q   <= 1'b0;
            t2_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            session_q  <= session_d;
            rn_q       <= rn_d;
            lfsr_q     <= lfsr_d;
            rx_sr_q    <= rx_sr_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_phase_q <= tx_phase_d;
            tx_sr_q    <= tx_sr_d;
            tx_left_q  <= tx_left_d;
            t1_cnt_q   <= t1_cnt_d;
            t2_run_q   <= t2_run_d;
            t2_cnt_q   <= t2_cnt_d;
        end
    end

endmodule

// File: tb/tb_rfid_tag_fsm.sv
// Directed bench for rfid_tag_fsm: inventory round trip, slot counting,
// T2 timeout, NAK, backpressure, frame length filtering and reset mid-reply.
module tb_rfid_tag_fsm;

    localparam int EPC_W = 96;
    localparam int T1    = 64;
    localparam int T2    = 2000;

    logic             clk = 1'b0;
    logic             rst, in_dat, in_vld, in_sof, in_eof, out_rdy;
    logic [15:0]      epc_pc  = 16'h3000;
    logic [EPC_W-1:0] epc_val = 96'hE200_1234_5678_9ABC_DEF0_1357;
    logic [15:0]      epc_crc = 16'hBEEF;
    logic             out_dat, out_vld, out_last;
    logic [1:0]       state_o;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] mlfsr;
    logic [15:0] exp_rn;
    logic [127:0] got;
    int          lat;
    bit          lok, sok, dok, saw;

    rfid_tag_fsm #(
        .EPC_W     (EPC_W),
        .LFSR_SEED (16'hACE1),
        .T1_CYCLES (T1),
        .T2_MAX    (T2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_dat   (in_dat),
        .in_vld   (in_vld),
        .in_sof   (in_sof),
        .in_eof   (in_eof),
        .epc_pc   (epc_pc),
        .epc_val  (epc_val),
        .epc_crc  (epc_crc),
        .out_dat  (out_dat),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_last (out_last),
        .state_o  (state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lstep(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    function automatic logic [4:0] crc5(input logic [16:0] b);
        logic [4:0] c;
        logic       f;
        c = 5'b01001;
        for (int i = 16; i >= 0; i--) begin
            f = c[4] ^ b[i];
            c = {c[3], c[2] ^ f, c[1], c[0], f};
        end
        return c;
    endfunction

    function automatic logic [21:0] qry(input logic [1:0] sess, input logic [3:0] q);
        logic [16:0] b;
        b = {4'b1000, 1'b0, 2'b00, 1'b0, 2'b00, sess, 1'b0, q};
        return {b, crc5(b)};
    endfunction

    // sof pulse, then n bits MSB first with eof on the last bit
    task automatic send_frame(input logic [31:0] v, input int n);
        @(negedge clk);
        in_sof = 1'b1;
        @(negedge clk);
        in_sof = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            in_dat = v[i];
            in_vld = 1'b1;
            in_eof = (i == 0);
            mlfsr  = lstep(mlfsr);
            @(negedge clk);
        end
        in_vld = 1'b0;
        in_eof = 1'b0;
        in_dat = 1'b0;
    endtask

    // Collect one reply; returns at the negedge after the final handshake
    task automatic collect(input int nbits, input bit stall, output logic [127:0] g,
                           output int l, output bit last_ok, output bit stall_ok,
                           output bit drop_ok);
        logic b;
        g = '0; l = 0; last_ok = 1'b1; stall_ok = 1'b1; drop_ok = 1'b1;
        while (out_vld !== 1'b1 && l < T1 + 50) begin
            @(negedge clk);
            l++;
        end
        if (out_vld !== 1'b1) begin
            last_ok = 1'b0;
            drop_ok = 1'b0;
            return;
        end
        for (int i = 0; i < nbits; i++) begin
            if (stall) begin
                out_rdy = 1'b0;
                b = out_dat;
                @(negedge clk);
                if (out_dat !== b || out_vld !== 1'b1) stall_ok = 1'b0;
                out_rdy = 1'b1;
            end
            g = {g[126:0], out_dat};
            if (out_last !== (i == nbits - 1) || out_vld !== 1'b1) last_ok = 1'b0;
            @(negedge clk);
        end
        drop_ok = (out_vld === 1'b0);
    endtask

    task automatic wait_quiet(input int n, output bit s);
        s = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (out_vld !== 1'b0) s = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_dat = 1'b0; in_vld = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        out_rdy = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mlfsr = 16'hACE1;
        total++; if (state_o !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state_o); end
        total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL reset_vld: got %b want 0", out_vld); end
        total++; if (out_dat !== 1'b0) begin bad++; $display("FAIL reset_dat: got %b want 0", out_dat); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last: got %b want 0", out_last); end
    endtask

    task automatic test_query_rn();
        send_frame({10'd0, qry(2'b01, 4'd0)}, 22);
        exp_rn = mlfsr;
        total++; if (state_o !== 2'd2) begin bad++; $display("FAIL query_state: got %0d want 2", state_o); end
        collect(16, 1'b0, got, lat, lok, sok, dok);
        total++; if (lat != T1) begin bad++; $display("FAIL query_t1: got %0d want %0d", lat, T1); end
        total++; if (got[15:0] !== exp_rn) begin bad++; $display("FAIL query_rn16: got %h want %h", got[15:0], exp_rn); end
        total++; if (!lok) begin bad++; $display("FAIL query_last: got 0 want 1"); end
        total++; if (!dok) begin bad++; $display("FAIL query_vld_drop: got 0 want 1"); end
    endtask

    task automatic test_ack_epc();
        send_frame({14'd0, 2'b01, exp_rn}, 18);
        total++; if (state_o !== 2'd3) begin bad++; $display("FAIL ack_state: got %0d want 3", state_o); end
        collect(128, 1'b0, got, lat, lok, sok, dok);
        total++; if (lat != T1) begin bad++; $display("FAIL ack_t1: got %0d want %0d", lat, T1); end
        total++; if (got !== {epc_pc, epc_val, epc_crc}) begin
            bad++; $display("FAIL ack_epc: got %h want %h", got, {epc_pc, epc_val, epc_crc});
        end
        total++; if (!lok || !dok) begin bad++; $display("FAIL ack_last_drop: got %b%b want 11", lok, dok); end
        send_frame({28'd0, 4'b0001}, 4);
        total++; if (state_o !== 2'd0) begin bad++; $display("FAIL rep_to_ready: got %0d want 0", state_o); end
        wait_quiet(T1 + 20, saw);
        total++; if (saw) begin bad++; $display("FAIL rep_no_reply: got vld=1 want 0"); end
    endtask

    task automatic test_ack_bad();
        send_frame({10'd0, qry(2'b01, 4'd0)}, 22);
        exp_rn = mlfsr;
        collect(16, 1'b0, got, lat, lok, sok, dok);
        total++; if (got[15:0] !== exp_rn) begin bad++; $display("FAIL ackbad_rn16: got %h want %h", got[15:0], exp_rn); end
        send_frame({14'd0, 2'b01, exp_rn ^ 16'h0001}, 18);
        total++; if (state_o !== 2'd1) begin bad++; $display("FAIL ackbad_state: got %0d want 1", state_o); end
        wait_quiet(T1 + 20, saw);
        total++; if (saw) begin bad++; $display("FAIL ackbad_no_reply: got vld=1 want 0"); end
    endtask

    task automatic test_slots();
        logic [15:0] l;
        // Pad with ignored 1-bit frames until the Query lands on slot 3
        for (int k = 0; k < 64; k++) begin
            l = mlfsr;
            repeat (22) l = lstep(l);
            if (l[1:0] == 2'b11) break;
            send_frame(32'd0, 1);
        end
        total++; if (state_o !== 2'd1) begin bad++; $display("FAIL pad_ignored: got %0d want 1", state_o); end
        send_frame({10'd0, qry(2'b01, 4'd2)}, 22);
        total++; if (state_o !== 2'd1) begin bad++; $display("FAIL slot_arb: got %0d want 1", state_o); end
        send_frame({28'd0, 4'b0010}, 4);
        send_frame({28'd0, 4'b0001}, 4);
        send_frame({28'd0, 4'b0001}, 4);
        wait_quiet(T1 + 10, saw);
        total++; if (saw || state_o !== 2'd1) begin
            bad++; $display("FAIL slot_count: got vld=%b state=%0d want 0/1", saw, state_o);
        end
        send_frame({28'd0, 4'b0001}, 4);
        exp_rn = mlfsr;
        total++; if (state_o !== 2'd2) begin bad++; $display("FAIL slot_reply: got %0d want 2", state_o); end
        collect(16, 1'b0, got, lat, lok, sok, dok);
        total++; if (got[15:0] !== exp_rn || lat != T1) begin
            bad++; $display("FAIL slot_rn16: got %h lat %0d want %h lat %0d", got[15:0], lat, exp_rn, T1);
        end
    endtask

    task automatic test_t2();
        repeat (T2 - 1) @(negedge clk);
        total++; if (state_o !== 2'd2) begin bad++; $display("FAIL t2_early: got %0d want 2", state_o); end
        @(negedge clk);
        total++; if (state_o !== 2'd1) begin bad++; $display("FAIL t2_expire: got %0d want 1", state_o); end
    endtask

    task automatic test_nak();
        send_frame({10'd0, qry(2'b00, 4'd0)}, 22);
        exp_rn = mlfsr;
        collect(16, 1'b0, got, lat, lok, sok, dok);
        send_frame({14'd0, 2'b01, exp_rn}, 18);
        collect(128, 1'b0, got, lat, lok, sok, dok);
        total++; if (state_o !== 2'd3) begin bad++; $display("FAIL nak_pre_state: got %0d want 3", state_o); end
        send_frame({24'd0, 8'hC0}, 8);
        total++; if (state_o !== 2'd1) begin bad++; $display("FAIL nak_state: got %0d want 1", state_o); end
        wait_quiet(T1 + 20, saw);
        total++; if (saw) begin bad++; $display("FAIL nak_no_reply: got vld=1 want 0"); end
    endtask

    task automatic test_stall();
        send_frame({10'd0, qry(2'b01, 4'd0)}, 22);
        exp_rn = mlfsr;
        collect(16, 1'b1, got, lat, lok, sok, dok);
        total++; if (got[15:0] !== exp_rn) begin bad++; $display("FAIL stall_rn16: got %h want %h", got[15:0], exp_rn); end
        total++; if (!sok) begin bad++; $display("FAIL stall_hold: got 0 want 1"); end
        total++; if (!lok || !dok) begin bad++; $display("FAIL stall_last: got %b%b want 11", lok, dok); end
        send_frame({13'd0, 19'b01_1010_1011_1100_1101}, 19);
        total++; if (state_o !== 2'd2) begin bad++; $display("FAIL len19_state: got %0d want 2", state_o); end
        wait_quiet(T1 + 20, saw);
        total++; if (saw) begin bad++; $display("FAIL len19_no_reply: got vld=1 want 0"); end
    endtask

    task automatic test_crc5();
        send_frame({10'd0, qry(2'b01, 4'd0) ^ 22'h1}, 22);
        exp_rn = mlfsr;
`ifdef RFID_TAG_CRC5_EN
        wait_quiet(T1 + 20, saw);
        total++; if (saw) begin bad++; $display("FAIL crc_bad_reply: got vld=1 want 0"); end
        total++; if (state_o !== 2'd2) begin bad++; $display("FAIL crc_bad_state: got %0d want 2", state_o); end
`else
        collect(16, 1'b0, got, lat, lok, sok, dok);
        total++; if (got[15:0] !== exp_rn) begin bad++; $display("FAIL crc_off_rn16: got %h want %h", got[15:0], exp_rn); end
`endif
    endtask

    task automatic test_rst_mid();
        int n;
        send_frame({10'd0, qry(2'b01, 4'd0)}, 22);
        n = 0;
        while (out_vld !== 1'b1 && n < T1 + 50) begin
            @(negedge clk);
            n++;
        end
        total++; if (out_vld !== 1'b1) begin bad++; $display("FAIL rstmid_start: got vld=0 want 1"); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mlfsr = 16'hACE1;
        total++; if (out_vld !== 1'b0 || state_o !== 2'd0) begin
            bad++; $display("FAIL rstmid_abort: got vld=%b state=%0d want 0/0", out_vld, state_o);
        end
        wait_quiet(T1 + 20, saw);
        total++; if (saw) begin bad++; $display("FAIL rstmid_quiet: got vld=1 want 0"); end
    endtask

    initial begin
        test_reset();
        test_query_rn();
        test_ack_epc();
        test_ack_bad();
        test_slots();
        test_t2();
        test_nak();
        test_stall();
        test_crc5();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1);
    end

endmodule
